// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA timing plus a 2x-replicated 320x240 grayscale frame-buffer reader.
// Pipeline: counters (stage 0) -> RAM address (stage 1) -> aligned outputs (stage 2).
module vga_frame_reader #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned SRC_W    = 320
) (
    input  logic        clk,
    input  logic        reset,
    output logic [16:0] ram_addr,
    input  logic [7:0]  ram_data,
    output logic [7:0]  pixel_out,
    output logic [16:0] pixel_addr,
    output logic        active_area,
    output logic        vsync,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        frame_start
);

    localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_STOP  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_STOP  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [16:0] ROW_STEP = 17'(SRC_W);

    // Stage 0: raster position and running source-row base address
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [16:0] row_base_q, row_base_d;
    logic        h_wrap, v_wrap;
    logic        active_s0, hsync_s0, vsync_s0, frame_start_s0;
    logic [8:0]  x_src;
    logic [16:0] ram_addr_d;

    // Stage 1: RAM address is in flight; timing flags travel alongside it
    logic [16:0] ram_addr_q;
    logic        active_s1_q, hsync_s1_q, vsync_s1_q, frame_start_s1_q;

    // Stage 2: registered outputs, all updated on the same edge
    logic [7:0]  pixel_out_q;
    logic [16:0] pixel_addr_q;
    logic        active_q, vsync_q, hsync_n_q, vsync_n_q, frame_start_q;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        end

        active_s0      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hsync_s0       = (h_cnt_q >= HS_START) && (h_cnt_q < HS_STOP);
        vsync_s0       = (v_cnt_q >= VS_START) && (v_cnt_q < VS_STOP);
        frame_start_s0 = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

        // Each source row feeds two output lines, so step after the odd one
        row_base_d = row_base_q;
        if (h_wrap && v_wrap) begin
            row_base_d = 17'd0;
        end else if (h_wrap && v_cnt_q[0] && (v_cnt_q < V_ACT)) begin
            row_base_d = row_base_q + ROW_STEP;
        end

        x_src      = h_cnt_q[9:1];
        ram_addr_d = active_s0 ? row_base_q + {8'd0, x_src} : 17'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q    <= 10'd0;
            v_cnt_q    <= 10'd0;
            row_base_q <= 17'd0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            row_base_q <= row_base_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr_q       <= 17'd0;
            active_s1_q      <= 1'b0;
            hsync_s1_q       <= 1'b0;
            vsync_s1_q       <= 1'b0;
            frame_start_s1_q <= 1'b0;
        end else begin
            ram_addr_q       <= ram_addr_d;
            active_s1_q      <= active_s0;
            hsync_s1_q       <= hsync_s0;
            vsync_s1_q       <= vsync_s0;
            frame_start_s1_q <= frame_start_s0;
        end
    end

    // ram_data at this edge belongs to ram_addr_q, so pixel and address stay paired
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_out_q   <= 8'd0;
            pixel_addr_q  <= 17'd0;
            active_q      <= 1'b0;
            vsync_q       <= 1'b0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            pixel_out_q   <= active_s1_q ? ram_data : 8'd0;
            pixel_addr_q  <= active_s1_q ? ram_addr_q : 17'd0;
            active_q      <= active_s1_q;
            vsync_q       <= vsync_s1_q;
            hsync_n_q     <= ~hsync_s1_q;
            vsync_n_q     <= ~vsync_s1_q;
            frame_start_q <= frame_start_s1_q;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign pixel_out   = pixel_out_q;
    assign pixel_addr  = pixel_addr_q;
    assign active_area = active_q;
    assign vsync       = vsync_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign frame_start = frame_start_q;

endmodule
